glyph_scanner: RTL and testbench

GLYPH_SCANNER -- requirements
Module: glyph_scanner

---
 rtl/glyph_scanner.sv | 115 +++++++++++
 tb/tb_glyph_scanner.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/glyph_scanner.sv
`default_nettype none
// glyph_scanner: fetches one COLSxROWS glyph bitmap per accepted character and
// streams it out pixel by pixel, row-major, over a valid/ready handshake. Rev 1.0

module glyph_scanner #(
  parameter int COLS       = 5,
  parameter int ROWS       = 7,
  parameter int DATA_WIDTH = 35,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] char_code,
  input  logic                  char_valid,
  output logic                  char_ready,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_on,
  output logic [2:0]            pix_row,
  output logic [2:0]            pix_col,
  output logic                  pix_last
);

  localparam int         IDX_W    = $clog2(DATA_WIDTH);
  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);
  localparam logic [2:0] LAST_COL = 3'(COLS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   bitmap_q, bitmap_d;
  logic [2:0]              row_q, row_d;
  logic [2:0]              col_q, col_d;

  logic                    in_stream;
  logic                    at_last;
  logic [IDX_W-1:0]        bit_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      bitmap_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      bitmap_q <= bitmap_d;
      row_q    <= row_d;
      col_q    <= col_d;
    end
  end

  assign in_stream = (state_q == STREAM);
  assign at_last   = (row_q == LAST_ROW) && (col_q == LAST_COL);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    bitmap_d = bitmap_q;
    row_d    = row_q;
    col_d    = col_q;
    case (state_q)
      IDLE: begin
        if (char_valid) begin
          addr_d  = char_code;
          state_d = FETCH;
        end
      end
      FETCH: begin
        // The only cycle rom_data is sampled; later ROM changes cannot leak in.
        bitmap_d = rom_data;
        row_d    = '0;
        col_d    = '0;
        state_d  = STREAM;
      end
      STREAM: begin
        if (pix_ready) begin
          if (at_last) begin
            state_d = IDLE;
          end else if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + 3'd1;
          end else begin
            col_d = col_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // MSB of the bitmap is row 0, column 0.
  assign bit_idx = IDX_W'(DATA_WIDTH - 1)
                 - (IDX_W'(row_q) * IDX_W'(COLS) + IDX_W'(col_q));

  assign char_ready = (state_q == IDLE);
  assign rom_addr   = addr_q;
  assign pix_valid  = in_stream;
  assign pix_on     = in_stream & bitmap_q[bit_idx];
  assign pix_row    = in_stream ? row_q : 3'd0;
  assign pix_col    = in_stream ? col_q : 3'd0;
  assign pix_last   = in_stream & at_last;

endmodule

`default_nettype wire

// File: tb/tb_glyph_scanner.sv
`default_nettype none
// tb_glyph_scanner: table-driven glyph vectors plus hand-written reset sequences.
`timescale 1ns/1ps

module tb_glyph_scanner;

  localparam int COLS = 5;
  localparam int ROWS = 7;
  localparam int DW   = 35;
  localparam int AW   = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] char_code = '0;
  logic          char_valid = 1'b0;
  logic          char_ready;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data = '0;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic          pix_on;
  logic [2:0]    pix_row;
  logic [2:0]    pix_col;
  logic          pix_last;

  glyph_scanner #(
    .COLS(COLS), .ROWS(ROWS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .char_code(char_code), .char_valid(char_valid), .char_ready(char_ready),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_on(pix_on),
    .pix_row(pix_row), .pix_col(pix_col), .pix_last(pix_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] code;
    logic [DW-1:0] rom;
    logic [DW-1:0] rom_after;
    bit            stall;
    bit            inject;
    int            exp_ones;
    int            exp_cycles;
  } vec_t;

  vec_t vecs[7];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_glyph(input vec_t v, input int idx);
    int          cyc, ones, r, c;
    bit          done;
    logic        exp_on;
    logic [16:0] exp_t, act_t;
    check($sformatf("v%0d_idle_ready", idx), {63'd0, char_ready}, 64'd1);
    char_code  = v.code;
    char_valid = 1'b1;
    rom_data   = v.rom;
    step();
    char_valid = 1'b0;
    check($sformatf("v%0d_fetch", idx), {pix_valid, char_ready, rom_addr}, {1'b0, 1'b0, v.code});
    step();
    rom_data = v.rom_after;
    r = 0; c = 0; cyc = 0; ones = 0; done = 1'b0;
    while (!done && cyc < 200) begin
      cyc++;
      pix_ready = v.stall ? (cyc % 2 == 0) : 1'b1;
      if (v.inject && cyc == 5) begin
        char_code  = 7'h5A;
        char_valid = 1'b1;
      end
      exp_on = v.rom[DW-1-(r*COLS+c)];
      exp_t  = {1'b1, 3'(r), 3'(c), exp_on, (r == ROWS-1 && c == COLS-1), 1'b0, v.code};
      act_t  = {pix_valid, pix_row, pix_col, pix_on, pix_last, char_ready, rom_addr};
      check($sformatf("v%0d_px_cyc%0d", idx, cyc), act_t, exp_t);
      if (pix_ready) begin
        if (exp_on) ones++;
        if (r == ROWS-1 && c == COLS-1) done = 1'b1;
        else if (c == COLS-1) begin c = 0; r++; end
        else c++;
      end
      step();
    end
    check($sformatf("v%0d_stream_cycles", idx), 64'(cyc), 64'(v.exp_cycles));
    check($sformatf("v%0d_lit_pixels", idx), 64'(ones), 64'(v.exp_ones));
    check($sformatf("v%0d_back_idle", idx),
          {pix_valid, pix_last, pix_on, pix_row, pix_col, char_ready, rom_addr},
          {1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, v.code});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{7'h41, 35'h7FFFFFFFF, 35'h7FFFFFFFF, 1'b0, 1'b0, 35, 35};
    vecs[1] = '{7'h42, 35'h400000001, 35'h000000000, 1'b0, 1'b0,  2, 35};
    vecs[2] = '{7'h43, 35'h400000001, 35'h7FFFFFFFF, 1'b1, 1'b0,  2, 70};
    vecs[3] = '{7'h44, 35'h155555555, 35'h6AAAAAAAA, 1'b0, 1'b0, 17, 35};
    vecs[4] = '{7'h41, 35'h7FFFFFFFF, 35'h000000000, 1'b0, 1'b1, 35, 35};
    vecs[5] = '{7'h5A, 35'h0F0F0F0F0, 35'h7FFFFFFFF, 1'b0, 1'b0, 16, 35};
    vecs[6] = '{7'h33, 35'h123456789, 35'h000000000, 1'b1, 1'b0, 15, 70};

    // Reset values must appear before any clock edge.
    #1;
    check("reset_async",
          {pix_valid, pix_last, pix_on, pix_row, pix_col, char_ready, rom_addr},
          {1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 7'd0});
    step();
    step();
    check("reset_held",
          {pix_valid, pix_last, pix_on, pix_row, pix_col, char_ready, rom_addr},
          {1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 7'd0});
    rst_n = 1'b1;

    // vecs[4] leaves char_valid high with 0x5A, so vecs[5] is a back-to-back accept.
    for (int i = 0; i < 6; i++) run_glyph(vecs[i], i);

    // Abort a glyph with reset while pixel (3,2) is on the bus.
    char_code  = 7'h33;
    rom_data   = 35'h7FFFFFFFF;
    char_valid = 1'b1;
    pix_ready  = 1'b1;
    step();
    char_valid = 1'b0;
    step();
    repeat (17) step();
    check("abort_position", {pix_valid, pix_row, pix_col}, {1'b1, 3'd3, 3'd2});
    rst_n = 1'b0;
    #1;
    check("abort_async",
          {pix_valid, pix_last, pix_on, pix_row, pix_col, char_ready, rom_addr},
          {1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 7'd0});
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("abort_quiet%0d", k), {pix_valid, char_ready, rom_addr}, {1'b0, 1'b1, 7'd0});
    end

    run_glyph(vecs[6], 6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
